// File: rtl/mnist_image_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mnist_image_loader_pkg
//  Description : Shared image geometry, word width and loader state encoding
//                for the MNIST image loader and the CNN model top.
//  Revision    : 1.0 - initial release
// ============================================================================
package mnist_image_loader_pkg;

    localparam int BIT_SIZE        = 18;
    localparam int INPUT_WIDTH     = 28;
    localparam int INPUT_HEIGHT    = 28;
    localparam int CHANNEL_SIZE    = 1;
    localparam int PIXEL_COUNT     = INPUT_WIDTH * INPUT_HEIGHT * CHANNEL_SIZE;
    localparam int COUNT_BIT       = 10;
    localparam int FRAME_COUNT_BIT = 16;

    // Loader state: LOAD accepts pixels, FULL holds a completed image
    typedef enum logic [0:0] {
        LOAD = 1'b0,
        FULL = 1'b1
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/mnist_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mnist_image_loader
//  Description : Assembles a serial start-of-frame tagged pixel stream into a
//                flat channel/row/column image buffer, holds it stable with
//                image_valid until the consumer acknowledges, then reopens.
//  Revision    : 1.0 - initial release
// ============================================================================
module mnist_image_loader #(
    parameter int BIT_SIZE        = mnist_image_loader_pkg::BIT_SIZE,
    parameter int INPUT_WIDTH     = mnist_image_loader_pkg::INPUT_WIDTH,
    parameter int INPUT_HEIGHT    = mnist_image_loader_pkg::INPUT_HEIGHT,
    parameter int CHANNEL_SIZE    = mnist_image_loader_pkg::CHANNEL_SIZE,
    parameter int PIXEL_COUNT     = INPUT_WIDTH * INPUT_HEIGHT * CHANNEL_SIZE,
    parameter int COUNT_BIT       = mnist_image_loader_pkg::COUNT_BIT,
    parameter int FRAME_COUNT_BIT = mnist_image_loader_pkg::FRAME_COUNT_BIT
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_sof,
    input  logic [BIT_SIZE-1:0]             in_pixel,
    output logic [PIXEL_COUNT*BIT_SIZE-1:0] image_buffer,
    output logic                            image_valid,
    input  logic                            image_ack,
    output logic                            sync_error,
    output logic [COUNT_BIT-1:0]            pixel_index,
    output logic [FRAME_COUNT_BIT-1:0]      frames_loaded
);

    import mnist_image_loader_pkg::*;

    localparam logic [COUNT_BIT-1:0] c_last_index = COUNT_BIT'(PIXEL_COUNT - 1);
    localparam logic [COUNT_BIT-1:0] c_one_index  = COUNT_BIT'(1);

    loader_state_t              r_state;
    logic [BIT_SIZE-1:0]        r_pixels [PIXEL_COUNT];
    logic [COUNT_BIT-1:0]       r_pixel_index;
    logic [FRAME_COUNT_BIT-1:0] r_frames_loaded;
    logic                       r_sync_error;

    logic                       w_beat;
    logic                       w_wr_en;
    logic [COUNT_BIT-1:0]       w_wr_addr;

    assign in_ready      = (r_state == LOAD);
    assign image_valid   = (r_state == FULL);
    assign w_beat        = in_valid & in_ready;
    assign sync_error    = r_sync_error;
    assign pixel_index   = r_pixel_index;
    assign frames_loaded = r_frames_loaded;

    // Write port: a start-of-frame word always lands at index 0 (also on
    // resync); untagged words land at the running index unless orphaned.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        if (w_beat) begin
            if (in_sof) begin
                w_wr_en   = 1'b1;
                w_wr_addr = '0;
            end else if (r_pixel_index != '0) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_pixel_index;
            end
        end
    end

    // Image storage; only written while loading, so it is frozen in FULL
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIXEL_COUNT; i++) begin
                r_pixels[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_pixels[w_wr_addr] <= in_pixel;
        end
    end

    // Loader FSM with write index, frame counter and framing-error pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= LOAD;
            r_pixel_index   <= '0;
            r_frames_loaded <= '0;
            r_sync_error    <= 1'b0;
        end else begin
            r_sync_error <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_beat) begin
                        if (in_sof) begin
                            // Fresh frame, or resync that drops the partial one
                            r_pixel_index <= c_one_index;
                            r_sync_error  <= (r_pixel_index != '0);
                        end else if (r_pixel_index == '0) begin
                            // Orphan pixel with no frame in progress: dropped
                            r_sync_error <= 1'b1;
                        end else if (r_pixel_index == c_last_index) begin
                            r_pixel_index   <= '0;
                            r_frames_loaded <= r_frames_loaded + 1'b1;
                            r_state         <= FULL;
                        end else begin
                            r_pixel_index <= r_pixel_index + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (image_ack) begin
                        r_state <= LOAD;
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    // Flatten storage into the channel/row/column word layout
    for (genvar gi = 0; gi < PIXEL_COUNT; gi++) begin : g_flatten
        assign image_buffer[gi*BIT_SIZE +: BIT_SIZE] = r_pixels[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_mnist_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mnist_image_loader
//  Description : Directed, scoreboard-based bench for mnist_image_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mnist_image_loader;

    localparam int BS  = 18;
    localparam int PC  = 784;
    localparam int CB  = 10;
    localparam int FCB = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sof = 1'b0;
    logic [BS-1:0]     in_pixel = '0;
    logic [PC*BS-1:0]  image_buffer;
    logic              image_valid;
    logic              image_ack = 1'b0;
    logic              sync_error;
    logic [CB-1:0]     pixel_index;
    logic [FCB-1:0]    frames_loaded;

    int n_cmp  = 0;
    int n_fail = 0;
    int sync_cnt = 0;

    logic [BS-1:0] exp_q[$];
    logic [BS-1:0] last_img [PC];

    mnist_image_loader dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sof        (in_sof),
        .in_pixel      (in_pixel),
        .image_buffer  (image_buffer),
        .image_valid   (image_valid),
        .image_ack     (image_ack),
        .sync_error    (sync_error),
        .pixel_index   (pixel_index),
        .frames_loaded (frames_loaded)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (sync_error === 1'b1) sync_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [BS-1:0] word(input int n);
        return image_buffer[n*BS +: BS];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; image_ack = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        sync_cnt = 0;
    endtask

    // One beat; the scoreboard follows the frame framing rules
    task automatic send(input logic [BS-1:0] v, input logic sof);
        int guard;
        guard = 0;
        in_valid = 1'b1; in_pixel = v; in_sof = sof;
        while (in_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) chk("ready_timeout", 32'(in_ready), 32'd1);
        if (sof) begin
            exp_q.delete();
            exp_q.push_back(v);
        end else if (exp_q.size() != 0) begin
            exp_q.push_back(v);
        end
        tick();
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        int guard;
        guard = 0;
        while (image_valid !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        chk({tag, "_valid"}, 32'(image_valid), 32'd1);
        chk({tag, "_qsize"}, 32'(exp_q.size()), 32'(PC));
        for (int n = 0; n < PC; n++) begin
            logic [BS-1:0] e;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            last_img[n] = e;
            chk($sformatf("%s_word%0d", tag, n), 32'(word(n)), 32'(e));
        end
    endtask

    task automatic ack();
        image_ack = 1'b1;
        tick();
        image_ack = 1'b0;
        chk("ack_valid_low", 32'(image_valid), 32'd0);
        chk("ack_ready_high", 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_valid", 32'(image_valid), 32'd0);
        chk("rst_index", 32'(pixel_index), 32'd0);
        chk("rst_frames", 32'(frames_loaded), 32'd0);
        chk("rst_sync", 32'(sync_error), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_buf_zero", 32'(image_buffer == '0), 32'd1);
        do_reset();

        // Nominal frame, latency of image_valid after the last beat
        for (int n = 0; n < PC; n++) begin
            if (n == PC - 1) chk("nom_valid_before_last", 32'(image_valid), 32'd0);
            send(BS'(n), n == 0);
        end
        chk("nom_valid_after_last", 32'(image_valid), 32'd1);
        chk("nom_index_wrap", 32'(pixel_index), 32'd0);
        check_frame("nom");
        chk("nom_frames", 32'(frames_loaded), 32'd1);
        chk("nom_sync_cnt", 32'(sync_cnt), 32'd0);

        // Hold: pixels offered while FULL are refused
        in_valid = 1'b1; in_pixel = 18'h12345; in_sof = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; in_sof = 1'b0;
        for (int n = 0; n < PC; n++)
            chk($sformatf("hold_word%0d", n), 32'(word(n)), 32'(last_img[n]));
        chk("hold_valid", 32'(image_valid), 32'd1);
        chk("hold_index", 32'(pixel_index), 32'd0);
        ack();

        // Second frame
        for (int n = 0; n < PC; n++) send(BS'(1000 + n), n == 0);
        check_frame("f2");
        chk("f2_frames", 32'(frames_loaded), 32'd2);

        // Resync mid-frame
        do_reset();
        for (int n = 0; n < 300; n++) send(BS'(5000 + n), n == 0);
        chk("rs_index_300", 32'(pixel_index), 32'd300);
        send(18'h3FFFF, 1'b1);
        chk("rs_sync_pulse", 32'(sync_error), 32'd1);
        chk("rs_index_1", 32'(pixel_index), 32'd1);
        for (int n = 1; n < PC; n++) begin
            if (n == PC - 1) chk("rs_valid_before_last", 32'(image_valid), 32'd0);
            send(BS'(7000 + n), 1'b0);
        end
        check_frame("rs");
        chk("rs_word0", 32'(word(0)), 32'h3FFFF);
        chk("rs_frames", 32'(frames_loaded), 32'd1);
        chk("rs_sync_cnt", 32'(sync_cnt), 32'd1);

        // Orphan pixels before any sof, back to back
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(BS'(900 + i), 1'b0);
            chk("orph_pulse", 32'(sync_error), 32'd1);
            chk("orph_index", 32'(pixel_index), 32'd0);
        end
        tick();
        chk("orph_pulse_end", 32'(sync_error), 32'd0);
        chk("orph_sync_cnt", 32'(sync_cnt), 32'd5);
        for (int n = 0; n < PC; n++) send(BS'(n), n == 0);
        check_frame("orph");
        chk("orph_frames", 32'(frames_loaded), 32'd1);
        chk("orph_sync_cnt_end", 32'(sync_cnt), 32'd5);

        // Random gaps with ack held during idle LOAD cycles
        do_reset();
        for (int n = 0; n < PC; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                image_ack = 1'b1;
                tick();
                image_ack = 1'b0;
            end
            send(BS'(n), n == 0);
        end
        check_frame("gap");
        chk("gap_frames", 32'(frames_loaded), 32'd1);
        chk("gap_sync_cnt", 32'(sync_cnt), 32'd0);

        // Asynchronous reset at pixel 400, between clock edges
        ack();
        for (int n = 0; n < 400; n++) send(BS'(3000 + n), n == 0);
        chk("mr_index_400", 32'(pixel_index), 32'd400);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_index", 32'(pixel_index), 32'd0);
        chk("mr_frames", 32'(frames_loaded), 32'd0);
        chk("mr_valid", 32'(image_valid), 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd1);
        chk("mr_sync", 32'(sync_error), 32'd0);
        chk("mr_buf_zero", 32'(image_buffer == '0), 32'd1);
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        for (int n = 0; n < PC; n++) send(BS'(PC - n), n == 0);
        check_frame("mr");
        chk("mr_frames_after", 32'(frames_loaded), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
